btn_event: RTL and testbench
============================

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 27_000_000, meaning the hold time in clk cycles before a long-press event (1 s at 27 MHz).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 5_400_000, meaning the interval in clk cycles between repeat events while long-held (200 ms).
REQ-003 The block SHALL have parameter CNT_W, default 25, meaning the timer width, with LONG_CYCLES and REPEAT_CYCLES each ≥2 and <2^CNT_W.
REQ-004 clk  input  1  the single clock; all state SHALL be on its rising edge.
REQ-005 n_reset  input  1  reset, asynchronous and active-low.
REQ-006 db_in  input  1  debounced button level from DeBounce DB_out, 1 = pressed, already synchronous to clk.
REQ-007 press_pulse  output  1  one-cycle strobe on press.
REQ-008 release_pulse  output  1  one-cycle strobe on release.
REQ-009 long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
REQ-010 repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES while long-held.
REQ-011 held  output  1  high while state is not IDLE.
REQ-012 was_long  output  1  qualifies release_pulse: 1 if the released press had reached LONG.
REQ-013 press_count  output  8  count of press events.

Function
REQ-014 All outputs SHALL be registered; db_in SHALL be registered once into db_q for edge detection.
REQ-015 FSM states SHALL be IDLE, SHORT and LONG.
REQ-016 In IDLE, db_in=1 with db_q=0 SHALL move to SHORT, clear the timer, pulse press_pulse and increment press_count, all on that same edge (1-cycle latency from db_in).
REQ-017 In SHORT, the timer SHALL increment each cycle; the edge where the timer equals LONG_CYCLES-1 SHALL move to LONG, pulse long_pulse and clear the timer, so long_pulse occurs exactly LONG_CYCLES cycles after press_pulse.
REQ-018 In LONG, the timer SHALL increment each cycle; at REPEAT_CYCLES-1 it SHALL pulse repeat_pulse, clear the timer and remain in LONG.
REQ-019 In SHORT or LONG, db_in=0 SHALL move to IDLE and pulse release_pulse, with was_long=1 if leaving LONG and 0 otherwise.
REQ-020 was_long SHALL hold its value until the next release.
REQ-021 When release coincides with timer terminal count, release SHALL win: no long_pulse or repeat_pulse, and was_long reflects the pre-transition state.
REQ-022 press_count SHALL wrap 255→0 without saturation.
REQ-023 At most one of press_pulse, long_pulse, repeat_pulse or release_pulse SHALL be high in any cycle.
REQ-024 The timer SHALL never exceed max(LONG_CYCLES, REPEAT_CYCLES)-1.

Reset
REQ-025 n_reset=0 SHALL immediately force state IDLE and zero the timer, db_q and all outputs, including press_count and was_long.
REQ-026 If db_in is high when reset deasserts, the first clock edge SHALL see a rising edge (db_q=0) and emit press_pulse.
REQ-027 Reset mid-operation SHALL discard the press in progress and emit no release_pulse.

Structure
REQ-028 Package btn_event_pkg SHALL hold the state enum typedef (IDLE, SHORT, LONG) and the default LONG_CYCLES and REPEAT_CYCLES constants.
REQ-029 btn_event SHALL be one module with no sub-module; timer, FSM and press counter are too small to split.
REQ-030 In the system, btn_event SHALL be instantiated directly downstream of DeBounce on the same clk and n_reset.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4; e0 = press_pulse edge)
REQ-031 Short press (db_in high 5 cycles) SHALL give press_pulse at e0, release_pulse at e0+5 with was_long=0, and no long_pulse.
REQ-032 A 20-cycle hold SHALL give long_pulse at e0+8, repeat_pulse at e0+12 and e0+16, and release_pulse at e0+20 with was_long=1 and no repeat at e0+20.
REQ-033 An exactly 8-cycle hold SHALL give release_pulse at e0+8 with was_long=0 and no long_pulse.
REQ-034 Reset asserted in LONG with db_in held SHALL drive all outputs 0 asynchronously, then give press_pulse on the first edge after deassertion with press_count=1.
REQ-035 256 short presses SHALL leave press_count at 0, with 255 observed after the 255th press.
REQ-036 The bench SHALL check the one-hot pulse rule (REQ-023) on every cycle of all scenarios.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } state_e;

  // 1 s hold and 200 ms repeat interval at a 27 MHz clock.
  localparam int unsigned DEF_LONG_CYCLES   = 27_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 5_400_000;

endpackage

// File: rtl/btn_event.sv
// Turns a debounced button level into press/release/long/repeat strobes,
// plus a held flag, a long-press qualifier and a wrapping press counter.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       db_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic       was_long,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             db_q;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             long_pulse_q, long_pulse_d;
  logic             repeat_pulse_q, repeat_pulse_d;
  logic             held_q, held_d;
  logic             was_long_q, was_long_d;
  logic [7:0]       press_count_q, press_count_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    timer_d         = timer_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    repeat_pulse_d  = 1'b0;
    was_long_d      = was_long_q;
    press_count_d   = press_count_q;

    case (state_q)
      IDLE: begin
        if (db_in && !db_q) begin
          state_d       = SHORT;
          timer_d       = '0;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
        end
      end
      SHORT: begin
        // Release is tested first so it wins over a coincident terminal count.
        if (!db_in) begin
          state_d         = IDLE;
          timer_d         = '0;
          release_pulse_d = 1'b1;
          was_long_d      = 1'b0;
        end else if (timer_q == LONG_LAST) begin
          state_d      = LONG;
          timer_d      = '0;
          long_pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LONG: begin
        if (!db_in) begin
          state_d         = IDLE;
          timer_d         = '0;
          release_pulse_d = 1'b1;
          was_long_d      = 1'b1;
        end else if (timer_q == REPEAT_LAST) begin
          timer_d        = '0;
          repeat_pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      db_q            <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      held_q          <= 1'b0;
      was_long_q      <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      timer_q         <= timer_d;
      db_q            <= db_in;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      held_q          <= held_d;
      was_long_q      <= was_long_d;
      press_count_q   <= press_count_d;
    end
  end

  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign repeat_pulse  = repeat_pulse_q;
  assign held          = held_q;
  assign was_long      = was_long_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event: expected strobes are queued as stimulus is
// driven and matched against the strobes the DUT emits.
module tb_btn_event;

  typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT} ev_e;

  typedef struct {
    ev_e        kind;
    int         cyc;
    logic [7:0] cnt;
    logic       wl;
  } exp_t;

  logic       clk;
  logic       n_reset;
  logic       db_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic       was_long;
  logic [7:0] press_count;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_wl  = 1'b0;

  btn_event #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .db_in        (db_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .was_long     (was_long),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input ev_e kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = m_cnt;
    e.wl   = m_wl;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_press"},   press_pulse,   0);
    check({tag, "_release"}, release_pulse, 0);
    check({tag, "_long"},    long_pulse,    0);
    check({tag, "_repeat"},  repeat_pulse,  0);
    check({tag, "_held"},    held,          0);
    check({tag, "_was_long"}, was_long,     0);
    check({tag, "_count"},   press_count,   0);
  endtask

  // Press held for n edges starting at e0; queues the full expected event list.
  task automatic hold(input int n);
    int e0;
    e0 = cyc + 1;
    m_cnt = m_cnt + 8'd1;
    push(EV_PRESS, e0);
    if (n > 8) begin
      push(EV_LONG, e0 + 8);
      for (int t = e0 + 12; t < e0 + n; t += 4) push(EV_REPEAT, t);
    end
    m_wl = (n > 8);
    push(EV_RELEASE, e0 + n);
    db_in = 1'b1;
    repeat (n) @(negedge clk);
    db_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard consumer and per-cycle one-hot check.
  always @(negedge clk) begin
    int   np;
    ev_e  ok;
    exp_t e;
    if (n_reset === 1'b1) begin
      np = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
      check("one_hot", (np <= 1), 1);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_event_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (np > 0) begin
        ok = press_pulse   ? EV_PRESS   :
             release_pulse ? EV_RELEASE :
             long_pulse    ? EV_LONG    : EV_REPEAT;
        if (sb.size() == 0) begin
          check("unexpected_pulse_kind", ok, EV_NONE);
        end else begin
          e = sb.pop_front();
          check("ev_kind",     ok,          e.kind);
          check("ev_cycle",    cyc,         e.cyc);
          check("ev_count",    press_count, e.cnt);
          check("ev_was_long", was_long,    e.wl);
        end
      end
    end
  end

  initial begin
    int e0;
    db_in   = 1'b0;
    n_reset = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b1;
    @(negedge clk);

    // Short press, 20-cycle hold with repeats, exact-terminal release, then
    // a short press whose press event must still see was_long from the hold.
    hold(5);
    hold(20);
    check("was_long_after_20", was_long, 1);
    check("held_after_20", held, 0);
    hold(8);
    check("was_long_after_8", was_long, 0);
    hold(12);
    hold(3);

    // Reset while in LONG with the button still down.
    e0 = cyc + 1;
    m_cnt = m_cnt + 8'd1;
    push(EV_PRESS, e0);
    push(EV_LONG, e0 + 8);
    db_in = 1'b1;
    repeat (10) @(negedge clk);
    check("held_in_long", held, 1);
    #2 n_reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check("queue_empty_at_reset", sb.size(), 0);
    m_cnt = 8'd0;
    m_wl  = 1'b0;
    @(negedge clk);
    #2 n_reset = 1'b1;
    e0 = cyc + 1;
    m_cnt = 8'd1;
    push(EV_PRESS, e0);
    push(EV_RELEASE, e0 + 3);
    @(negedge clk);
    check("count_after_reset_press", press_count, 1);
    repeat (2) @(negedge clk);
    db_in = 1'b0;
    repeat (3) @(negedge clk);

    // Clear the counter, then 256 presses wrap it back to zero.
    #2 n_reset = 1'b0;
    #1;
    check("count_cleared", press_count, 0);
    m_cnt = 8'd0;
    m_wl  = 1'b0;
    @(negedge clk);
    #2 n_reset = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 256; i++) begin
      hold(2);
      if (i == 255) check("count_255", press_count, 255);
      if (i == 256) check("count_wrap", press_count, 0);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
